rf_access_arbiter: RTL and testbench

Shares the single-port register file between two requesters: M0, the command sequencer driven by UART RX frames, and M1, a secondary configuration/debug master. It grants one complete transaction at a time, either a single write or a read that completes when the register file returns valid data. Requester selection is round-robin. The block sits between both masters and the register file's Address/WrEn/RdEn/WrData/RdData/RdData_Valid interface, and every output is driven from registered state.

---
 rtl/rf_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/rf_access_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rf_access_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file access arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_e;

  // Read-data fill on timeout; callers take the low DW bits.
  localparam int unsigned FILL_W = 256;
  localparam logic [FILL_W-1:0] RD_TO_FILL = '1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic: round-robin on last-acknowledged master, or fixed
// M0 priority when RF_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import rf_arb_pkg::*;
(
`ifndef RF_ARB_FIXED_PRIO_EN
  input  logic CLK,
  input  logic RST,
  input  logic upd,
  input  mid_e upd_id,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt_vld_c,
  output mid_e gnt_id_c
);

  assign gnt_vld_c = req0 | req1;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign gnt_id_c = req0 ? M0 : M1;
`else
  mid_e last;

  // Pointer holds the master acknowledged most recently; the other wins ties.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last <= M0;
    end else if (upd) begin
      last <= upd_id;
    end
  end

  always_comb begin
    gnt_id_c = M0;
    if (req0 && req1) begin
      gnt_id_c = (last == M0) ? M1 : M0;
    end else if (req1) begin
      gnt_id_c = M1;
    end
  end
`endif

endmodule

// File: rtl/rf_access_arbiter.sv
// Arbitrates two masters onto the single-port register file, one complete
// transaction at a time. Define RF_ARB_FIXED_PRIO_EN for fixed M0 priority.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 4,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          M0_REQ,
  input  logic          M0_WE,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic          M0_ACK,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_RVLD,
  input  logic          M1_REQ,
  input  logic          M1_WE,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic          M1_ACK,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_RVLD,
  output logic [AW-1:0] Address,
  output logic          WrEn,
  output logic          RdEn,
  output logic [DW-1:0] WrData,
  input  logic [DW-1:0] RdData,
  input  logic          RdData_Valid,
  output logic          RD_TO_ERR,
  output logic          ARB_BUSY
);

  localparam int unsigned CW = 8;
  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_RD_WAIT = RD_WAIT;
  localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);
  localparam logic [DW-1:0] TO_FILL = RD_TO_FILL[DW-1:0];

  logic [1:0]    state, state_nxt;
  mid_e          win, win_nxt;
  logic          we, we_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] wdata_nxt, rdata0_nxt, rdata1_nxt;
  logic          wr_en_nxt, rd_en_nxt, to_err_nxt;
  logic          ack0_nxt, ack1_nxt, rvld0_nxt, rvld1_nxt;
  logic          gnt_vld_c;
  mid_e          gnt_id_c;

`ifndef RF_ARB_FIXED_PRIO_EN
  logic upd_c;
  mid_e upd_id_c;

  assign upd_c    = ack0_nxt | ack1_nxt;
  assign upd_id_c = ack1_nxt ? M1 : M0;
`endif

  rr_arb2 u_arb (
`ifndef RF_ARB_FIXED_PRIO_EN
    .CLK       (CLK),
    .RST       (RST),
    .upd       (upd_c),
    .upd_id    (upd_id_c),
`endif
    .req0      (M0_REQ),
    .req1      (M1_REQ),
    .gnt_vld_c (gnt_vld_c),
    .gnt_id_c  (gnt_id_c)
  );

  // Next-state and next-output logic; a pending ACK in IDLE is the read
  // completion phase and blocks a new grant for that cycle.
  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    we_nxt     = we;
    cnt_nxt    = cnt;
    addr_nxt   = Address;
    wdata_nxt  = WrData;
    rdata0_nxt = M0_RDATA;
    rdata1_nxt = M1_RDATA;
    wr_en_nxt  = 1'b0;
    rd_en_nxt  = 1'b0;
    to_err_nxt = 1'b0;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    rvld0_nxt  = 1'b0;
    rvld1_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (gnt_vld_c && !(M0_ACK || M1_ACK)) begin
          win_nxt   = gnt_id_c;
          we_nxt    = (gnt_id_c == M1) ? M1_WE : M0_WE;
          addr_nxt  = (gnt_id_c == M1) ? M1_ADDR : M0_ADDR;
          wdata_nxt = (gnt_id_c == M1) ? M1_WDATA : M0_WDATA;
          state_nxt = S_ISSUE;
          wr_en_nxt = we_nxt;
          rd_en_nxt = !we_nxt;
          ack0_nxt  = we_nxt && (gnt_id_c == M0);
          ack1_nxt  = we_nxt && (gnt_id_c == M1);
        end
      end
      S_ISSUE: begin
        cnt_nxt = '0;
        if (we) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RD_WAIT;
          rd_en_nxt = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          state_nxt = S_IDLE;
          ack0_nxt  = (win == M0);
          ack1_nxt  = (win == M1);
          rvld0_nxt = (win == M0);
          rvld1_nxt = (win == M1);
          if (win == M1) rdata1_nxt = RdData;
          else           rdata0_nxt = RdData;
        end else if (cnt == TO_LAST) begin
          state_nxt  = S_IDLE;
          cnt_nxt    = '0;
          ack0_nxt   = (win == M0);
          ack1_nxt   = (win == M1);
          to_err_nxt = 1'b1;
          if (win == M1) rdata1_nxt = TO_FILL;
          else           rdata0_nxt = TO_FILL;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          rd_en_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      win       <= M0;
      we        <= 1'b0;
      cnt       <= '0;
      Address   <= '0;
      WrData    <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      M0_ACK    <= 1'b0;
      M1_ACK    <= 1'b0;
      M0_RVLD   <= 1'b0;
      M1_RVLD   <= 1'b0;
      M0_RDATA  <= '0;
      M1_RDATA  <= '0;
      RD_TO_ERR <= 1'b0;
      ARB_BUSY  <= 1'b0;
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      we        <= we_nxt;
      cnt       <= cnt_nxt;
      Address   <= addr_nxt;
      WrData    <= wdata_nxt;
      WrEn      <= wr_en_nxt;
      RdEn      <= rd_en_nxt;
      M0_ACK    <= ack0_nxt;
      M1_ACK    <= ack1_nxt;
      M0_RVLD   <= rvld0_nxt;
      M1_RVLD   <= rvld1_nxt;
      M0_RDATA  <= rdata0_nxt;
      M1_RDATA  <= rdata1_nxt;
      RD_TO_ERR <= to_err_nxt;
      ARB_BUSY  <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a small register-file model;
// define RF_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_rf_access_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       M0_REQ, M0_WE, M1_REQ, M1_WE;
  logic [3:0] M0_ADDR, M1_ADDR;
  logic [7:0] M0_WDATA, M1_WDATA;
  logic       M0_ACK, M0_RVLD, M1_ACK, M1_RVLD;
  logic [7:0] M0_RDATA, M1_RDATA;
  logic [3:0] Address;
  logic       WrEn, RdEn;
  logic [7:0] WrData;
  logic [7:0] RdData = 8'h00;
  logic       RdData_Valid = 1'b0;
  logic       RD_TO_ERR, ARB_BUSY;

  logic       rf_resp_en;
  logic [7:0] mem [16];
  int         errors = 0;
  int         checks = 0;

  wire [35:0] all_outs = {M0_ACK, M0_RVLD, M0_RDATA, M1_ACK, M1_RVLD, M1_RDATA,
                          Address, WrEn, RdEn, WrData, RD_TO_ERR, ARB_BUSY};

  rf_access_arbiter dut (
    .CLK          (CLK),
    .RST          (RST),
    .M0_REQ       (M0_REQ),
    .M0_WE        (M0_WE),
    .M0_ADDR      (M0_ADDR),
    .M0_WDATA     (M0_WDATA),
    .M0_ACK       (M0_ACK),
    .M0_RDATA     (M0_RDATA),
    .M0_RVLD      (M0_RVLD),
    .M1_REQ       (M1_REQ),
    .M1_WE        (M1_WE),
    .M1_ADDR      (M1_ADDR),
    .M1_WDATA     (M1_WDATA),
    .M1_ACK       (M1_ACK),
    .M1_RDATA     (M1_RDATA),
    .M1_RVLD      (M1_RVLD),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .RD_TO_ERR    (RD_TO_ERR),
    .ARB_BUSY     (ARB_BUSY)
  );

  always #5 CLK = ~CLK;

  // Register file with one-cycle read latency; responses gated by rf_resp_en.
  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    RdData_Valid <= rf_resp_en && RdEn && !RdData_Valid;
    RdData       <= mem[Address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b0;
    M0_REQ = 0; M0_WE = 0; M0_ADDR = 0; M0_WDATA = 0;
    M1_REQ = 0; M1_WE = 0; M1_ADDR = 0; M1_WDATA = 0;
    rf_resp_en = 1'b1;
    repeat (2) cyc();
    chk("reset_outputs", 64'(all_outs), 64'h0);
    RST = 1'b1;
    cyc();
    chk("idle_after_reset", 64'(all_outs), 64'h0);

    // 1: single M0 write
    M0_REQ = 1; M0_WE = 1; M0_ADDR = 4'h3; M0_WDATA = 8'h5A;
    cyc();
    chk("t1_issue", {WrEn, RdEn, Address, WrData, M0_ACK, M1_ACK, ARB_BUSY},
        {1'b1, 1'b0, 4'h3, 8'h5A, 1'b1, 1'b0, 1'b1});
    M0_REQ = 0;
    cyc();
    chk("t1_done", {WrEn, M0_ACK, ARB_BUSY}, 3'b000);
    chk("t1_mem3", mem[3], 8'h5A);

    // 2: M1 read of address 3, one-cycle RF latency
    M1_REQ = 1; M1_WE = 0; M1_ADDR = 4'h3;
    cyc();
    chk("t2_issue", {RdEn, WrEn, Address, M1_ACK}, {1'b1, 1'b0, 4'h3, 1'b0});
    chk("t2_m0_quiet_a", {M0_ACK, M0_RVLD, M0_RDATA}, 10'h0);
    cyc();
    chk("t2_wait", {RdEn, Address, M1_ACK, M1_RVLD}, {1'b1, 4'h3, 1'b0, 1'b0});
    cyc();
    chk("t2_complete", {M1_ACK, M1_RVLD, M1_RDATA, RdEn}, {1'b1, 1'b1, 8'h5A, 1'b0});
    chk("t2_m0_quiet_b", {M0_ACK, M0_RVLD, M0_RDATA}, 10'h0);
    M1_REQ = 0;
    cyc();
    chk("t2_after", {M1_ACK, M1_RVLD, M1_RDATA}, {1'b0, 1'b0, 8'h5A});

`ifndef RF_ARB_FIXED_PRIO_EN
    // 3: both masters hold write requests; M1 was granted last
    M0_REQ = 1; M0_WE = 1; M0_ADDR = 4'h1; M0_WDATA = 8'h11;
    M1_REQ = 1; M1_WE = 1; M1_ADDR = 4'h2; M1_WDATA = 8'h22;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i % 2 == 0)
        chk("t3_grant", {M0_ACK, M1_ACK, WrEn, RdEn, Address, WrData},
            {1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11});
      else
        chk("t3_grant", {M0_ACK, M1_ACK, WrEn, RdEn, Address, WrData},
            {1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 8'h22});
      if (i == 3) begin M0_REQ = 0; M1_REQ = 0; end
      cyc();
      chk("t3_gap", {M0_ACK, M1_ACK, WrEn, RdEn, ARB_BUSY}, 5'b00000);
    end
    chk("t3_mem1", mem[1], 8'h11);
    chk("t3_mem2", mem[2], 8'h22);
`else
    // 6: fixed priority, both requesting; M0 keeps winning until it drops
    M0_REQ = 1; M0_WE = 1; M0_ADDR = 4'h1; M0_WDATA = 8'h11;
    M1_REQ = 1; M1_WE = 1; M1_ADDR = 4'h2; M1_WDATA = 8'h22;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_m0_grant", {M0_ACK, M1_ACK, WrEn, Address}, {1'b1, 1'b0, 1'b1, 4'h1});
      if (i == 2) M0_REQ = 0;
      cyc();
      chk("t6_gap", {M0_ACK, M1_ACK, WrEn}, 3'b000);
    end
    cyc();
    chk("t6_m1_grant", {M0_ACK, M1_ACK, WrEn, Address, WrData},
        {1'b0, 1'b1, 1'b1, 4'h2, 8'h22});
    M1_REQ = 0;
    cyc();
    chk("t6_done", {M1_ACK, WrEn}, 2'b00);
`endif

    // 4: M0 read with no response -> timeout after 15 RD_WAIT cycles
    rf_resp_en = 1'b0;
    M0_REQ = 1; M0_WE = 0; M0_ADDR = 4'h5;
    cyc();
    chk("t4_issue", {RdEn, Address, M0_ACK}, {1'b1, 4'h5, 1'b0});
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk("t4_wait", {RdEn, M0_ACK, RD_TO_ERR, ARB_BUSY}, 4'b1001);
    end
    cyc();
    chk("t4_timeout", {M0_ACK, M0_RVLD, M0_RDATA, RD_TO_ERR, RdEn, M1_ACK},
        {1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0});
    M0_REQ = 0;
    cyc();
    chk("t4_clear", {M0_ACK, RD_TO_ERR, M0_RDATA}, {1'b0, 1'b0, 8'hFF});
    M1_REQ = 1; M1_WE = 1; M1_ADDR = 4'h6; M1_WDATA = 8'h66;
    cyc();
    chk("t4_next_grant", {M1_ACK, WrEn, Address, WrData}, {1'b1, 1'b1, 4'h6, 8'h66});
    M1_REQ = 0;
    cyc();
    chk("t4_mem6", mem[6], 8'h66);

    // 5: reset while in RD_WAIT
    M0_REQ = 1; M0_WE = 0; M0_ADDR = 4'h3;
    cyc();
    cyc();
    chk("t5_in_wait", {RdEn, ARB_BUSY}, 2'b11);
    RST = 1'b0;
    M0_REQ = 0;
    #1;
    chk("t5_async_clear", 64'(all_outs), 64'h0);
    cyc();
    cyc();
    chk("t5_held", 64'(all_outs), 64'h0);
    RST = 1'b1;
    cyc();
    chk("t5_no_ack", 64'(all_outs), 64'h0);
    M0_REQ = 1; M0_WE = 1; M0_ADDR = 4'h7; M0_WDATA = 8'h77;
    M1_REQ = 1; M1_WE = 1; M1_ADDR = 4'h8; M1_WDATA = 8'h88;
    cyc();
`ifndef RF_ARB_FIXED_PRIO_EN
    chk("t5_first", {M0_ACK, M1_ACK, Address, WrData}, {1'b0, 1'b1, 4'h8, 8'h88});
    M1_REQ = 0;
    cyc();
    cyc();
    chk("t5_second", {M0_ACK, M1_ACK, Address, WrData}, {1'b1, 1'b0, 4'h7, 8'h77});
    M0_REQ = 0;
`else
    chk("t5_first", {M0_ACK, M1_ACK, Address, WrData}, {1'b1, 1'b0, 4'h7, 8'h77});
    M0_REQ = 0;
    cyc();
    cyc();
    chk("t5_second", {M0_ACK, M1_ACK, Address, WrData}, {1'b0, 1'b1, 4'h8, 8'h88});
    M1_REQ = 0;
`endif
    cyc();
    chk("t5_idle", {M0_ACK, M1_ACK, WrEn, RdEn, ARB_BUSY}, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
